// File: rtl/nou_rx_pkg.sv
// Shared types for the NOU receive path: header layout, FSM states and the
// descriptor record queued for software.
package nou_rx_pkg;

  localparam int SID_LSB    = 0;
  localparam int PKT_ID_LSB = 8;
  localparam int SRC_LSB    = 24;
  localparam int DST_LSB    = 32;
  localparam int TID_LSB    = 40;
  localparam int SZ_LSB     = 48;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic [7:0]  sid;
    logic [15:0] pkt_id;
    logic [7:0]  src_tile_id;
    logic [7:0]  trans_id;
    logic [15:0] data_sz;
    logic        tid_err;
  } rx_desc_t;

endpackage

// File: rtl/rpu_desc_fifo.sv
// Synchronous descriptor FIFO; head entry is always visible, push and pop may
// coincide in one cycle.
module rpu_desc_fifo
  import nou_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  rx_desc_t                 push_data,
  input  logic                     pop,
  output rx_desc_t                 head,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  rx_desc_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_pop  = pop && (cnt != '0);
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign do_push = push && ((cnt != FULL_CNT) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/rpu_pkt_rx.sv
// NOU receive packet unit: decodes single-flit headers, forwards local payload
// with zero latency, drops foreign packets and queues a descriptor per packet.
module rpu_pkt_rx
  import nou_rx_pkg::*;
#(
  parameter int FLIT_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        my_tile_id,
  input  logic              flit_vld,
  input  logic [FLIT_W-1:0] flit_data,
  output logic              flit_rdy,
  output logic              dat_vld,
  output logic [FLIT_W-1:0] dat_data,
  output logic              dat_last,
  input  logic              dat_rdy,
  output logic              desc_vld,
  input  logic              desc_rdy,
  output logic [7:0]        desc_sid,
  output logic [15:0]       desc_pkt_id,
  output logic [7:0]        desc_src_tile_id,
  output logic [7:0]        desc_trans_id,
  output logic [15:0]       desc_data_sz,
  output logic              desc_tid_err,
  output logic [15:0]       drop_cnt,
  output rx_state_e         state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Every channel transfers on the cycle where valid and ready are both high;
  // valid never waits on ready, and data is only meaningful while valid is high.

  logic [CW-1:0] fifo_cnt;
  logic [15:0]   rem_cnt;
  logic [7:0]    exp_tid;
  rx_desc_t      cur;
  rx_desc_t      hdr_desc;
  rx_desc_t      push_desc;
  rx_desc_t      head;
  logic          push;
  logic          hdr_acc;
  logic          local_hit;
  logic          xfer;

  assign hdr_desc = '{
    sid:         flit_data[SID_LSB +: 8],
    pkt_id:      flit_data[PKT_ID_LSB +: 16],
    src_tile_id: flit_data[SRC_LSB +: 8],
    trans_id:    flit_data[TID_LSB +: 8],
    data_sz:     flit_data[SZ_LSB +: 16],
    tid_err:     (flit_data[TID_LSB +: 8] != exp_tid)
  };

  assign local_hit = (flit_data[DST_LSB +: 8] == my_tile_id);
  assign hdr_acc   = (state == IDLE) && flit_vld && flit_rdy;
  assign xfer      = flit_vld && flit_rdy;
  assign dat_data  = flit_data;

  always_comb begin
    flit_rdy  = 1'b0;
    dat_vld   = 1'b0;
    dat_last  = 1'b0;
    push      = 1'b0;
    push_desc = cur;
    case (state)
      IDLE: begin
        flit_rdy = (fifo_cnt != FULL_CNT);
        if (hdr_acc && local_hit && (hdr_desc.data_sz == 16'd0)) begin
          push      = 1'b1;
          push_desc = hdr_desc;
        end
      end
      DATA: begin
        flit_rdy = dat_rdy;
        dat_vld  = flit_vld;
        dat_last = (rem_cnt == 16'd1);
        push     = xfer && (rem_cnt == 16'd1);
      end
      DROP: flit_rdy = 1'b1;
      default: flit_rdy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      rem_cnt  <= '0;
      exp_tid  <= '0;
      drop_cnt <= '0;
      cur      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hdr_acc) begin
            rem_cnt <= hdr_desc.data_sz;
            cur     <= hdr_desc;
            if (local_hit) begin
              exp_tid <= hdr_desc.trans_id + 8'd1;
              if (hdr_desc.data_sz != 16'd0) state <= DATA;
            end else begin
              if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
              if (hdr_desc.data_sz != 16'd0) state <= DROP;
            end
          end
        end
        DATA, DROP: begin
          if (xfer) begin
            rem_cnt <= rem_cnt - 16'd1;
            if (rem_cnt == 16'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rpu_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .push_data (push_desc),
    .pop       (desc_rdy),
    .head      (head),
    .cnt       (fifo_cnt)
  );

  assign desc_vld         = (fifo_cnt != '0);
  assign desc_sid         = head.sid;
  assign desc_pkt_id      = head.pkt_id;
  assign desc_src_tile_id = head.src_tile_id;
  assign desc_trans_id    = head.trans_id;
  assign desc_data_sz     = head.data_sz;
  assign desc_tid_err     = head.tid_err;

endmodule

// File: tb/tb_rpu_pkt_rx.sv
// Directed bench for rpu_pkt_rx: a per-cycle vector table plus hand-written
// full-FIFO, backpressure and mid-packet reset sequences.
module tb_rpu_pkt_rx;
  import nou_rx_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  my_tile_id;
  logic        flit_vld;
  logic [63:0] flit_data;
  logic        flit_rdy;
  logic        dat_vld;
  logic [63:0] dat_data;
  logic        dat_last;
  logic        dat_rdy;
  logic        desc_vld;
  logic        desc_rdy;
  logic [7:0]  desc_sid;
  logic [15:0] desc_pkt_id;
  logic [7:0]  desc_src_tile_id;
  logic [7:0]  desc_trans_id;
  logic [15:0] desc_data_sz;
  logic        desc_tid_err;
  logic [15:0] drop_cnt;
  rx_state_e   state;

  int passed = 0;
  int total  = 0;
  logic [56:0] exp_q[$];

  rpu_pkt_rx #(.FLIT_W(64), .DEPTH(4)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .my_tile_id       (my_tile_id),
    .flit_vld         (flit_vld),
    .flit_data        (flit_data),
    .flit_rdy         (flit_rdy),
    .dat_vld          (dat_vld),
    .dat_data         (dat_data),
    .dat_last         (dat_last),
    .dat_rdy          (dat_rdy),
    .desc_vld         (desc_vld),
    .desc_rdy         (desc_rdy),
    .desc_sid         (desc_sid),
    .desc_pkt_id      (desc_pkt_id),
    .desc_src_tile_id (desc_src_tile_id),
    .desc_trans_id    (desc_trans_id),
    .desc_data_sz     (desc_data_sz),
    .desc_tid_err     (desc_tid_err),
    .drop_cnt         (drop_cnt),
    .state            (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; flit_vld = 1'b0; flit_data = '0; dat_rdy = 1'b0; desc_rdy = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  // helpers
  function automatic logic [63:0] hdr(input logic [7:0] sid, input logic [15:0] pkt,
                                      input logic [7:0] src, input logic [7:0] dst,
                                      input logic [7:0] tid, input logic [15:0] sz);
    return {sz, tid, dst, src, pkt, sid};
  endfunction

  function automatic rx_desc_t mkd(input logic [7:0] sid, input logic [15:0] pkt,
                                   input logic [7:0] src, input logic [7:0] tid,
                                   input logic [15:0] sz, input logic err);
    rx_desc_t d;
    d.sid = sid; d.pkt_id = pkt; d.src_tile_id = src;
    d.trans_id = tid; d.data_sz = sz; d.tid_err = err;
    return d;
  endfunction

  function automatic rx_desc_t act_desc();
    rx_desc_t d;
    d.sid = desc_sid; d.pkt_id = desc_pkt_id; d.src_tile_id = desc_src_tile_id;
    d.trans_id = desc_trans_id; d.data_sz = desc_data_sz; d.tid_err = desc_tid_err;
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    else passed++;
  endtask

  // vector table
  typedef struct {
    logic        rs;
    logic        vld;
    logic [63:0] data;
    logic        drdy;
    logic        qrdy;
    logic        e_frdy;
    logic        e_dvld;
    logic        e_dlast;
    rx_state_e   e_state;
    logic        e_qvld;
    rx_desc_t    e_desc;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rs, input logic vld, input logic [63:0] data,
                              input logic drdy, input logic qrdy, input logic e_frdy,
                              input logic e_dvld, input logic e_dlast, input rx_state_e e_state,
                              input logic e_qvld, input rx_desc_t e_desc, input logic [15:0] e_drop);
    vec_t v;
    v.rs = rs; v.vld = vld; v.data = data; v.drdy = drdy; v.qrdy = qrdy;
    v.e_frdy = e_frdy; v.e_dvld = e_dvld; v.e_dlast = e_dlast; v.e_state = e_state;
    v.e_qvld = e_qvld; v.e_desc = e_desc; v.e_drop = e_drop;
    vq.push_back(v);
  endfunction

  initial begin
    rx_desc_t z;
    int xfers;
    z = '0;
    my_tile_id = 8'd7;
    do_reset();

    // local 3-flit packet, foreign 2-flit drop, local zero-payload, reset, tid sequence
    add(1, 0, 64'h0, 1, 0,  1, 0, 0, IDLE, 0, z, 16'd0);
    add(1, 1, hdr(8'h05, 16'h1234, 8'd3, 8'd7, 8'd0, 16'd3), 1, 0,  1, 0, 0, IDLE, 0, z, 16'd0);
    add(1, 1, 64'hA0, 1, 0,  1, 1, 0, DATA, 0, z, 16'd0);
    add(1, 1, 64'hA1, 1, 0,  1, 1, 0, DATA, 0, z, 16'd0);
    add(1, 1, 64'hA2, 1, 0,  1, 1, 1, DATA, 0, z, 16'd0);
    add(1, 0, 64'h0, 1, 1,  1, 0, 0, IDLE, 1, mkd(8'h05, 16'h1234, 8'd3, 8'd0, 16'd3, 1'b0), 16'd0);
    add(1, 0, 64'h0, 1, 0,  1, 0, 0, IDLE, 0, z, 16'd0);
    add(1, 1, hdr(8'h11, 16'h2222, 8'd4, 8'd9, 8'h33, 16'd2), 1, 0,  1, 0, 0, IDLE, 0, z, 16'd0);
    add(1, 1, 64'hB0, 1, 0,  1, 0, 0, DROP, 0, z, 16'd1);
    add(1, 1, 64'hB1, 0, 0,  1, 0, 0, DROP, 0, z, 16'd1);
    add(1, 0, 64'h0, 1, 0,  1, 0, 0, IDLE, 0, z, 16'd1);
    add(1, 1, hdr(8'h21, 16'h0001, 8'd2, 8'd7, 8'd1, 16'd0), 1, 0,  1, 0, 0, IDLE, 0, z, 16'd1);
    add(1, 0, 64'h0, 1, 1,  1, 0, 0, IDLE, 1, mkd(8'h21, 16'h0001, 8'd2, 8'd1, 16'd0, 1'b0), 16'd1);
    add(0, 0, 64'h0, 1, 0,  1, 0, 0, IDLE, 0, z, 16'd1);
    add(1, 1, hdr(8'h22, 16'h0002, 8'd2, 8'd7, 8'd0, 16'd0), 1, 0,  1, 0, 0, IDLE, 0, z, 16'd0);
    add(1, 1, hdr(8'h23, 16'h0003, 8'd2, 8'd7, 8'd1, 16'd0), 1, 1,  1, 0, 0, IDLE, 1, mkd(8'h22, 16'h0002, 8'd2, 8'd0, 16'd0, 1'b0), 16'd0);
    add(1, 1, hdr(8'h24, 16'h0004, 8'd2, 8'd7, 8'd5, 16'd0), 1, 1,  1, 0, 0, IDLE, 1, mkd(8'h23, 16'h0003, 8'd2, 8'd1, 16'd0, 1'b0), 16'd0);
    add(1, 1, hdr(8'h25, 16'h0005, 8'd2, 8'd7, 8'd6, 16'd0), 1, 1,  1, 0, 0, IDLE, 1, mkd(8'h24, 16'h0004, 8'd2, 8'd5, 16'd0, 1'b1), 16'd0);
    add(1, 0, 64'h0, 1, 1,  1, 0, 0, IDLE, 1, mkd(8'h25, 16'h0005, 8'd2, 8'd6, 16'd0, 1'b0), 16'd0);
    add(1, 0, 64'h0, 1, 0,  1, 0, 0, IDLE, 0, z, 16'd0);

    foreach (vq[i]) begin
      rstn = vq[i].rs; flit_vld = vq[i].vld; flit_data = vq[i].data;
      dat_rdy = vq[i].drdy; desc_rdy = vq[i].qrdy;
      #1;
      check($sformatf("v%0d flit_rdy", i), 64'(flit_rdy), 64'(vq[i].e_frdy));
      check($sformatf("v%0d dat_vld", i), 64'(dat_vld), 64'(vq[i].e_dvld));
      check($sformatf("v%0d dat_last", i), 64'(dat_last), 64'(vq[i].e_dlast));
      check($sformatf("v%0d state", i), 64'(state), 64'(vq[i].e_state));
      check($sformatf("v%0d desc_vld", i), 64'(desc_vld), 64'(vq[i].e_qvld));
      check($sformatf("v%0d drop_cnt", i), 64'(drop_cnt), 64'(vq[i].e_drop));
      if (vq[i].e_qvld) check($sformatf("v%0d desc", i), 64'(act_desc()), 64'(vq[i].e_desc));
      if (vq[i].e_dvld) check($sformatf("v%0d dat_data", i), dat_data, vq[i].data);
      tick();
    end
    rstn = 1'b1;

    // full FIFO: four zero-payload headers fill it, fifth waits for a pop
    do_reset();
    dat_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      flit_vld = 1'b1; flit_data = hdr(8'h40 + 8'(i), 16'(i), 8'd1, 8'd7, 8'(i), 16'd0);
      desc_rdy = 1'b0;
      #1;
      check($sformatf("full acc%0d", i), 64'(flit_rdy), 64'd1);
      exp_q.push_back(57'(mkd(8'h40 + 8'(i), 16'(i), 8'd1, 8'(i), 16'd0, 1'b0)));
      tick();
    end
    flit_data = hdr(8'h44, 16'd4, 8'd1, 8'd7, 8'd4, 16'd0);
    #1;
    check("full refuse", 64'(flit_rdy), 64'd0);
    check("full desc_vld", 64'(desc_vld), 64'd1);
    tick();
    desc_rdy = 1'b1;
    #1;
    check("full refuse during pop", 64'(flit_rdy), 64'd0);
    check("full pop0", 64'(act_desc()), 64'(exp_q.pop_front()));
    tick();
    #1;
    check("after pop acc", 64'(flit_rdy), 64'd1);
    check("full pop1", 64'(act_desc()), 64'(exp_q.pop_front()));
    exp_q.push_back(57'(mkd(8'h44, 16'd4, 8'd1, 8'd4, 16'd0, 1'b0)));
    tick();
    desc_rdy = 1'b0;
    flit_data = hdr(8'h45, 16'd5, 8'd1, 8'd7, 8'd5, 16'd0);
    #1;
    check("refill acc", 64'(flit_rdy), 64'd1);
    exp_q.push_back(57'(mkd(8'h45, 16'd5, 8'd1, 8'd5, 16'd0, 1'b0)));
    tick();
    flit_data = hdr(8'h46, 16'd6, 8'd1, 8'd7, 8'd6, 16'd0);
    #1;
    check("full again", 64'(flit_rdy), 64'd0);
    tick();
    flit_vld = 1'b0; desc_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (exp_q.size() == 0) begin
        check("drain empty", 64'(desc_vld), 64'd0);
        break;
      end
      check($sformatf("drain vld%0d", k), 64'(desc_vld), 64'd1);
      check($sformatf("drain desc%0d", k), 64'(act_desc()), 64'(exp_q.pop_front()));
      tick();
    end
    desc_rdy = 1'b0;

    // backpressure: dat_rdy alternates 1,0,... during a 4-flit packet
    do_reset();
    dat_rdy = 1'b1;
    flit_vld = 1'b1; flit_data = hdr(8'h50, 16'h5555, 8'd6, 8'd7, 8'd0, 16'd4);
    tick();
    xfers = 0;
    for (int j = 0; j < 20 && xfers < 4; j++) begin
      flit_data = 64'hD0 + 64'(xfers);
      dat_rdy = (j % 2 == 0);
      #1;
      check($sformatf("bp flit_rdy%0d", j), 64'(flit_rdy), 64'(dat_rdy));
      check($sformatf("bp dat_vld%0d", j), 64'(dat_vld), 64'd1);
      check($sformatf("bp dat_last%0d", j), 64'(dat_last), 64'(xfers == 3));
      check($sformatf("bp dat_data%0d", j), dat_data, 64'hD0 + 64'(xfers));
      if (dat_rdy) xfers++;
      tick();
    end
    check("bp transfers", 64'(xfers), 64'd4);
    flit_vld = 1'b0;
    #1;
    check("bp state", 64'(state), 64'(IDLE));
    check("bp desc", 64'(act_desc()), 64'(mkd(8'h50, 16'h5555, 8'd6, 8'd0, 16'd4, 1'b0)));
    check("bp desc_vld", 64'(desc_vld), 64'd1);

    // reset mid-DATA after a drop has been counted
    do_reset();
    dat_rdy = 1'b1;
    flit_vld = 1'b1; flit_data = hdr(8'h60, 16'd6, 8'd1, 8'd3, 8'd0, 16'd0);
    tick();
    flit_data = hdr(8'h61, 16'd7, 8'd1, 8'd7, 8'd0, 16'd4);
    tick();
    flit_data = 64'hE0; tick();
    flit_data = 64'hE1;
    #1;
    check("mid drop_cnt", 64'(drop_cnt), 64'd1);
    check("mid state", 64'(state), 64'(DATA));
    tick();
    rstn = 1'b0; flit_vld = 1'b0;
    tick();
    rstn = 1'b1;
    #1;
    check("rst state", 64'(state), 64'(IDLE));
    check("rst desc_vld", 64'(desc_vld), 64'd0);
    check("rst drop_cnt", 64'(drop_cnt), 64'd0);
    check("rst flit_rdy", 64'(flit_rdy), 64'd1);
    check("rst dat_vld", 64'(dat_vld), 64'd0);
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
